nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 12 +
 rtl/nibble_serial_adder_fa4.sv | 23 ++
 rtl/nibble_serial_adder.sv | 115 +++++++++++
 tb/tb_nibble_serial_adder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared widths, FSM encoding and frame-length default
package nibble_serial_adder_pkg;

    localparam int NIB_W       = 4;
    localparam int MAX_NIB_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_fa4.sv
// rtl/nibble_serial_adder_fa4.sv - 4-bit ripple-carry adder built from full-adder cells
module nibble_serial_adder_fa4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - framed nibble-serial adder with a single-entry skid-free output register
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int MAX_NIB = MAX_NIB_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NIB_W-1:0] s,
    output logic             out_last,
    output logic             co,
    output logic             err
);

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             out_valid_d, out_last_d, co_d, err_d;
    logic [NIB_W-1:0] s_d;

    logic             in_acc;
    logic             cin_mux;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_c;
    logic             produce;
    logic             overflow;
    logic             frame_end;

    assign in_ready = !out_valid || out_ready;
    assign in_acc   = in_valid && in_ready;
    assign cin_mux  = in_first ? ci : carry_q;

    nibble_serial_adder_fa4 fa4_inst (
        .a    (a),
        .b    (b),
        .cin  (cin_mux),
        .sum  (nib_sum),
        .cout (nib_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            s         <= '0;
            out_last  <= 1'b0;
            co        <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
            s         <= s_d;
            out_last  <= out_last_d;
            co        <= co_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid && !out_ready;
        s_d         = s;
        out_last_d  = out_last;
        co_d        = co;
        err_d       = err;
        produce     = 1'b0;
        overflow    = 1'b0;
        frame_end   = 1'b0;

        if (in_acc) begin
            unique case (state_q)
                IDLE: begin
                    // A stray continuation beat outside a frame is swallowed.
                    if (in_first) produce = 1'b1;
                    else          err_d   = 1'b1;
                end
                RUN: begin
                    produce = 1'b1;
                    if (in_first) err_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (produce) begin
            // cnt_q holds beats already taken; reaching MAX_NIB means this one is one too many.
            overflow    = (state_q == RUN) && !in_first && !in_last && (cnt_q == 4'(MAX_NIB));
            frame_end   = in_last || overflow;
            out_valid_d = 1'b1;
            s_d         = nib_sum;
            out_last_d  = frame_end;
            co_d        = frame_end && nib_c;
            carry_d     = frame_end ? 1'b0 : nib_c;
            cnt_d       = frame_end ? 4'd0 : (in_first ? 4'd1 : cnt_q + 4'd1);
            state_d     = frame_end ? IDLE : RUN;
            if (overflow) err_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench with an arithmetic frame model
module tb_nibble_serial_adder;

    localparam int MAXN = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       ci = 1'b0;
    logic       in_first = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] s;
    logic       out_last;
    logic       co;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int s;
        int last;
        int co;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];

    bit m_in_frame = 0;
    int m_carry = 0;
    int m_count = 0;
    bit m_err = 0;

    logic       prev_hold = 1'b0;
    logic [3:0] prev_s = '0;
    logic       prev_last = 1'b0;
    logic       prev_co = 1'b0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.MAX_NIB(MAXN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .out_last  (out_last),
        .co        (co),
        .err       (err)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_beat(input int aa, input int bb, input int cc,
                                       input bit f, input bit l);
        int  total;
        bit  over;
        bit  fin;
        beat_t e;
        if (!m_in_frame && !f) begin
            m_err = 1;
            return;
        end
        if (m_in_frame && f) m_err = 1;
        if (f) begin
            m_carry = cc;
            m_count = 0;
        end
        m_count++;
        total = aa + bb + m_carry;
        over  = !l && (m_count > MAXN);
        fin   = l || over;
        if (over) m_err = 1;
        e.s    = total % 16;
        e.last = fin;
        e.co   = fin ? total / 16 : 0;
        exp_q.push_back(e);
        m_carry    = fin ? 0 : total / 16;
        m_in_frame = !fin;
    endfunction

    always @(negedge clk) begin
        beat_t e;
        beat_t o;
        if (rst_n) begin
            check("in_ready_rule", in_ready, (!out_valid || out_ready));
            check("err_flag", err, m_err);
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_s", s, prev_s);
                check("hold_last", out_last, prev_last);
                check("hold_co", co, prev_co);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got s=%0d last=%0d with no beat pending", s, out_last);
                end else begin
                    e = exp_q.pop_front();
                    check("out_s", s, e.s);
                    check("out_last", out_last, e.last);
                    check("out_co", co, e.co);
                end
                o.s = s;
                o.last = out_last;
                o.co = co;
                obs_q.push_back(o);
            end
            prev_hold = out_valid && !out_ready;
            prev_s    = s;
            prev_last = out_last;
            prev_co   = co;
            if (in_valid && in_ready) model_beat(a, b, ci, in_first, in_last);
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic send(input logic [3:0] aa, input logic [3:0] bb, input bit cc,
                        input bit f, input bit l, output int waits);
        in_valid = 1'b1;
        a = aa;
        b = bb;
        ci = cc;
        in_first = f;
        in_last = l;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, required acceptance", waits);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        m_in_frame = 0;
        m_carry = 0;
        m_count = 0;
        m_err = 0;
        exp_q.delete();
    endtask

    task automatic leave_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int w1;
        int w2;
        enter_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_out_last", out_last, 0);
        check("rst_co", co, 0);
        check("rst_err", err, 0);
        leave_reset();

        // single-beat frame 9+8+1
        send(4'd9, 4'd8, 1'b1, 1'b1, 1'b1, w);
        check("single_valid_next", out_valid, 1);
        check("single_s_next", s, 2);
        drain();
        check("single_count", obs_q.size(), 1);
        check("single_s", obs_q[0].s, 2);
        check("single_co", obs_q[0].co, 1);
        check("single_last", obs_q[0].last, 1);

        // 0x0FF + 0x001, LSB first
        obs_q.delete();
        send(4'hF, 4'h1, 1'b0, 1'b1, 1'b0, w);
        send(4'hF, 4'h0, 1'b0, 1'b0, 1'b0, w1);
        send(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, w2);
        check("ripple_waits", w1 + w2, 0);
        drain();
        check("ripple_count", obs_q.size(), 3);
        check("ripple_s0", obs_q[0].s, 0);
        check("ripple_s1", obs_q[1].s, 0);
        check("ripple_s2", obs_q[2].s, 1);
        check("ripple_last0", obs_q[0].last, 0);
        check("ripple_last1", obs_q[1].last, 0);
        check("ripple_last2", obs_q[2].last, 1);
        check("ripple_co", obs_q[2].co, 0);

        // backpressure mid-frame on 0x1234 + 0x4321
        obs_q.delete();
        fork
            begin
                send(4'h4, 4'h1, 1'b0, 1'b1, 1'b0, w);
                send(4'h3, 4'h2, 1'b0, 1'b0, 1'b0, w);
                send(4'h2, 4'h3, 1'b0, 1'b0, 1'b0, w1);
                send(4'h1, 4'h4, 1'b0, 1'b0, 1'b1, w);
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready_low", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("bp_stalled", (w1 >= 3) ? 1 : 0, 1);
        drain();
        check("bp_count", obs_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("bp_s", obs_q[i].s, 5);
            check("bp_last", obs_q[i].last, (i == 3) ? 1 : 0);
        end

        // nine beats with no in_last
        obs_q.delete();
        for (int i = 0; i < 9; i++) send(4'd1, 4'd1, 1'b0, (i == 0), 1'b0, w);
        drain();
        check("ovf_count", obs_q.size(), 9);
        check("ovf_last8", obs_q[7].last, 0);
        check("ovf_last9", obs_q[8].last, 1);
        check("ovf_s9", obs_q[8].s, 2);
        check("ovf_err", err, 1);
        obs_q.delete();
        send(4'd1, 4'd1, 1'b0, 1'b0, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_idle_no_out", obs_q.size(), 0);
        send(4'd2, 4'd3, 1'b1, 1'b1, 1'b1, w);
        drain();
        check("ovf_next_s", obs_q[0].s, 6);

        // stray beat in IDLE after a clean reset
        @(posedge clk);
        #2;
        enter_reset();
        leave_reset();
        #1;
        check("clean_err", err, 0);
        send(4'd5, 4'd5, 1'b0, 1'b0, 1'b0, w);
        repeat (3) @(posedge clk);
        #1;
        check("stray_no_out", obs_q.size(), 0);
        check("stray_out_valid", out_valid, 0);
        check("stray_err", err, 1);
        send(4'h8, 4'h8, 1'b0, 1'b1, 1'b0, w);
        send(4'h7, 4'h8, 1'b0, 1'b0, 1'b1, w);
        drain();
        check("stray_next_count", obs_q.size(), 2);
        check("stray_next_s0", obs_q[0].s, 0);
        check("stray_next_s1", obs_q[1].s, 0);
        check("stray_next_co", obs_q[1].co, 1);

        // reset mid-frame while an output is held
        out_ready = 1'b0;
        send(4'hF, 4'hF, 1'b1, 1'b1, 1'b0, w);
        check("pre_rst_valid", out_valid, 1);
        #1;
        enter_reset();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_s", s, 0);
        check("midrst_err", err, 0);
        check("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        leave_reset();
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_out", obs_q.size(), 0);
        send(4'd1, 4'd1, 1'b0, 1'b1, 1'b1, w);
        drain();
        check("midrst_new_s", obs_q[0].s, 2);
        check("midrst_new_co", obs_q[0].co, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
